// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID operands and the load in EX
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rd,
  output logic       hazard
);
  assign hazard = id_ex_mem_read && id_ex_rd != REG_ZERO &&
                  (id_rs == id_ex_rd || (id_uses_rt && id_rt == id_ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller with memory wait sequencing, watchdog and stall counter
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_access,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t     state, state_nx;
  logic [9:0] wait_cnt;
  logic       hazard, timeout_hit, exit_wait, mem_stall, go;
  hazard_detect u_hazard (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .hazard         (hazard)
  );
  always_comb begin
    timeout_hit   = state == MEM_WAIT && wait_cnt == 10'(TIMEOUT - 1);
    exit_wait     = state == MEM_WAIT && (mem_ready || timeout_hit);
    mem_stall     = state == MEM_WAIT ? !exit_wait : ex_mem_access && !mem_ready;
    state_nx      = mem_stall ? MEM_WAIT : RUN;
    go            = !mem_stall && (ex_branch_taken || !hazard);
    mem_req       = state == MEM_WAIT || ex_mem_access;
    pc_en         = go;
    if_id_en      = go;
    if_id_flush   = !mem_stall && ex_branch_taken;
    id_ex_en      = !mem_stall;
    id_ex_flush   = !mem_stall && (ex_branch_taken || hazard);
    ex_mem_en     = !mem_stall;
    mem_wb_bubble = mem_stall;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= state == MEM_WAIT && !exit_wait ? wait_cnt + 10'd1 : '0;
      if (timeout_hit && !mem_ready) mem_timeout <= 1'b1;
      if (!pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Generates enable and flush/bubble controls for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Detects load-use hazards and taken-branch flushes.
- Sequences multi-cycle data-memory accesses through a req/ready handshake with a timeout watchdog and a saturating stall counter.

Parameters:
- TIMEOUT, 64, max MEM_WAIT cycles before a forced exit; legal range 1..1023.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_mem_access  in  1  instruction in EX_MEM performs a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- mem_req  out  1  data memory request.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF_ID register enable.
- if_id_flush  out  1  IF_ID register loads a NOP.
- id_ex_en  out  1  ID_EX register enable.
- id_ex_flush  out  1  ID_EX register loads a bubble (all controls 0).
- ex_mem_en  out  1  EX_MEM register enable.
- mem_wb_bubble  out  1  MEM_WB captures Reg_Write=0 this cycle.
- mem_timeout  out  1  sticky error: a memory wait timed out.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock and reset: clk, rising edge. rst_n is asynchronous and active-low.
- Reset values: state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0.
- All other outputs are combinational from state and inputs. With quiet inputs during or after reset: every enable=1, every flush/bubble=0, mem_req=0.
- FSM states: RUN, MEM_WAIT.
- mem_req = ex_mem_access in RUN. mem_req = 1 in MEM_WAIT.
- RUN with ex_mem_access=1 and mem_ready=0:
  - Enter MEM_WAIT next cycle.
  - This cycle: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1.
- RUN with ex_mem_access=1 and mem_ready=1: zero-wait access, no stall.
- MEM_WAIT:
  - Freeze PC, IF_ID, ID_EX and EX_MEM; mem_wb_bubble=1.
  - wait_cnt increments each cycle.
- Exit from MEM_WAIT:
  - Normal exit is the cycle mem_ready=1. That cycle all enables=1 and mem_wb_bubble=0; next state is RUN and wait_cnt clears.
  - Timeout exit: if wait_cnt reaches TIMEOUT-1 without mem_ready, that cycle behaves as a normal exit. mem_timeout sets and stays set until reset.
- Load-use hazard: hazard = id_ex_mem_read AND id_ex_rd≠0 AND (id_rs==id_ex_rd OR (id_uses_rt AND id_rt==id_ex_rd)). On hazard: pc_en=0, if_id_en=0, id_ex_flush=1. Single cycle; the hazard clears once the load advances.
- Taken branch: if_id_flush=1, id_ex_flush=1, pc_en=1.
- Priority, highest first:
  1. Memory stall (wait-entry cycle or MEM_WAIT). Branch and hazard are ignored; the EX stage is frozen, so both re-present on the exit cycle.
  2. Branch flush. The load-use stall is suppressed because the dependent instruction is squashed.
  3. Load-use stall.
- Exit cycle: hazard and branch logic are evaluated as in RUN.
- stall_cnt: +1 per cycle with pc_en=0; saturates at all-ones.
- Reset mid-MEM_WAIT: immediate return to RUN with counters cleared; mem_req drops combinationally.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - the REG_ZERO constant (5'd0);
  - the default TIMEOUT.
- One sub-module, hazard_detect: purely combinational load-use compare; its output feeds the FSM priority logic.
- The FSM and both counters stay in the top level.

Test Plan:
- Reset with rst_n=0 asynchronously mid-cycle -> state RUN, stall_cnt=0, mem_timeout=0; with quiet inputs all enables=1 and all flushes=0.
- Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1. Same case with id_ex_rd=0 -> no stall.
- Branch and load-use together: ex_branch_taken=1 with a hazard present -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait: ex_mem_access=1, mem_ready low for 3 cycles then high -> the 3 stall cycles (entry cycle plus 2 MEM_WAIT) show enables=0 and mem_wb_bubble=1. The 4th cycle shows enables=1 with state back to RUN. stall_cnt=3.
- Timeout with TIMEOUT=4: mem_ready never asserted -> forced exit in the 5th cycle (entry + 4 MEM_WAIT); mem_timeout=1 and stays 1. A zero-wait access (mem_ready=1 same cycle) -> no stall.
- stall_cnt saturation with CNT_W=4: 20 stall cycles -> stall_cnt holds 15.
